// File: rtl/rgmii_tx_gearbox.sv
// rgmii_tx_gearbox
//
// Purpose:
//   Sits directly in front of the output DDR flops on the RGMII transmit path.
//   It turns the MAC-side GMII byte stream into rising/falling-edge pairs for
//   the data, TX_CTL and forwarded-clock ODDRs. Everything runs from one
//   125 MHz clock.
//   - 1000M: each byte goes out in one cycle as two nibbles.
//   - 10/100M: each byte is split into two nibble periods of N cycles
//     (N = 5 at 100M, N = 50 at 10M). The block also generates the slow
//     forwarded clock and throttles the MAC with mii_tx_ce.
//
// Ports:
//   clk               125 MHz transmit clock
//   rst               asynchronous reset, active-high
//   gmii_txd[7:0]     MAC transmit byte
//   gmii_tx_en        MAC transmit enable
//   gmii_tx_er        MAC transmit error
//   speed[1:0]        00 = 10M, 01 = 100M, 1x = 1000M
//   mii_tx_ce         byte strobe to the MAC (combinational)
//   txd_d1/txd_d2     rising/falling data nibble for the data ODDR
//   txctl_d1/txctl_d2 rising/falling TX_CTL
//   txclk_d1/txclk_d2 rising/falling half of the forwarded TXC
//
// Configuration:
//   RGMII_TX_ER_EN  when defined, txctl_d2 = tx_en ^ tx_er.
//                   When undefined, gmii_tx_er is ignored and txctl_d2 = tx_en.

module rgmii_tx_gearbox (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] gmii_txd,
   input  logic       gmii_tx_en,
   input  logic       gmii_tx_er,
   input  logic [1:0] speed,
   output logic       mii_tx_ce,
   output logic [3:0] txd_d1,
   output logic [3:0] txd_d2,
   output logic       txctl_d1,
   output logic       txctl_d2,
   output logic       txclk_d1,
   output logic       txclk_d2
);

   localparam logic [5:0] CNT_LAST_100M = 6'd4;
   localparam logic [5:0] CNT_LAST_10M  = 6'd49;
   localparam logic [5:0] CNT_HALF_10M  = 6'd25;

   logic [5:0] cnt_q, cnt_d;
   logic       nibble_sel_q, nibble_sel_d;
   logic [7:0] byte_reg_q, byte_reg_d;
   logic       en_reg_q, en_reg_d;
   logic [1:0] speed_reg_q, speed_reg_d;
`ifdef RGMII_TX_ER_EN
   logic       er_reg_q, er_reg_d;
`endif

   logic [3:0] txd_rise_q, txd_rise_d;
   logic [3:0] txd_fall_q, txd_fall_d;
   logic       ctl_rise_q, ctl_rise_d;
   logic       ctl_fall_q, ctl_fall_d;
   logic       clk_rise_q, clk_rise_d;
   logic       clk_fall_q, clk_fall_d;

   logic [5:0] cnt_last;
   logic       boundary;
   logic [3:0] nibble;

   // A byte boundary occurs on every cycle in 1000M mode.
   // In 10/100M mode it is the last cycle of the high-nibble period.
   always_comb begin
      cnt_last = speed_reg_q[0] ? CNT_LAST_100M : CNT_LAST_10M;
      boundary = speed_reg_q[1] || ((cnt_q == cnt_last) && nibble_sel_q);
   end

   assign mii_tx_ce = boundary && !rst;

   // Period sequencing.
   // At a boundary, the new byte and the new speed are captured together.
   // The sequence then restarts at cnt 0 with the low nibble, which also
   // covers the counter clear on a mode change.
   always_comb begin
      cnt_d        = cnt_q;
      nibble_sel_d = nibble_sel_q;
      byte_reg_d   = byte_reg_q;
      en_reg_d     = en_reg_q;
      speed_reg_d  = speed_reg_q;
`ifdef RGMII_TX_ER_EN
      er_reg_d     = er_reg_q;
`endif
      if (boundary) begin
         cnt_d        = 6'd0;
         nibble_sel_d = 1'b0;
         byte_reg_d   = gmii_txd;
         en_reg_d     = gmii_tx_en;
         speed_reg_d  = speed;
`ifdef RGMII_TX_ER_EN
         er_reg_d     = gmii_tx_er;
`endif
      end else if (cnt_q == cnt_last) begin
         cnt_d        = 6'd0;
         nibble_sel_d = ~nibble_sel_q;
      end else begin
         cnt_d        = cnt_q + 6'd1;
      end
   end

   // The ODDR inputs are computed from the next state.
   // This makes the registered outputs line up with the cnt/nibble_sel
   // values that are loaded on the same edge, so a captured byte appears
   // one cycle after its boundary.
   always_comb begin
      ctl_rise_d = en_reg_d;
`ifdef RGMII_TX_ER_EN
      ctl_fall_d = en_reg_d ^ er_reg_d;
`else
      ctl_fall_d = en_reg_d;
`endif
      nibble = nibble_sel_d ? byte_reg_d[7:4] : byte_reg_d[3:0];
      if (speed_reg_d[1]) begin
         txd_rise_d = byte_reg_d[3:0];
         txd_fall_d = byte_reg_d[7:4];
         clk_rise_d = 1'b1;
         clk_fall_d = 1'b0;
      end else if (speed_reg_d[0]) begin
         // 25 MHz from 5 cycles: high for 2.5 cycles, using the half-cycle at cnt 2.
         txd_rise_d = nibble;
         txd_fall_d = nibble;
         clk_rise_d = (cnt_d <= 6'd2);
         clk_fall_d = (cnt_d <= 6'd1);
      end else begin
         txd_rise_d = nibble;
         txd_fall_d = nibble;
         clk_rise_d = (cnt_d < CNT_HALF_10M);
         clk_fall_d = (cnt_d < CNT_HALF_10M);
      end
   end

   // State and output registers.
   // An asynchronous reset discards any in-flight byte and returns the block to 1000M mode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q        <= 6'd0;
         nibble_sel_q <= 1'b0;
         byte_reg_q   <= 8'd0;
         en_reg_q     <= 1'b0;
         speed_reg_q  <= 2'b10;
`ifdef RGMII_TX_ER_EN
         er_reg_q     <= 1'b0;
`endif
         txd_rise_q   <= 4'd0;
         txd_fall_q   <= 4'd0;
         ctl_rise_q   <= 1'b0;
         ctl_fall_q   <= 1'b0;
         clk_rise_q   <= 1'b0;
         clk_fall_q   <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         nibble_sel_q <= nibble_sel_d;
         byte_reg_q   <= byte_reg_d;
         en_reg_q     <= en_reg_d;
         speed_reg_q  <= speed_reg_d;
`ifdef RGMII_TX_ER_EN
         er_reg_q     <= er_reg_d;
`endif
         txd_rise_q   <= txd_rise_d;
         txd_fall_q   <= txd_fall_d;
         ctl_rise_q   <= ctl_rise_d;
         ctl_fall_q   <= ctl_fall_d;
         clk_rise_q   <= clk_rise_d;
         clk_fall_q   <= clk_fall_d;
      end
   end

   assign txd_d1   = txd_rise_q;
   assign txd_d2   = txd_fall_q;
   assign txctl_d1 = ctl_rise_q;
   assign txctl_d2 = ctl_fall_q;
   assign txclk_d1 = clk_rise_q;
   assign txclk_d2 = clk_fall_q;

endmodule

// File: tb/tb_rgmii_tx_gearbox.sv
// tb_rgmii_tx_gearbox
//
// Self-checking bench for rgmii_tx_gearbox.
//
// Reference model:
//   Each time the model predicts a byte boundary, it writes out the complete
//   per-cycle ODDR waveform for the next byte, in the mode chosen at that
//   boundary, onto a queue.
//   Each cycle, one entry is popped and compared with the DUT outputs.
//   The MAC strobe is expected on the cycle that empties the queue.

module tb_rgmii_tx_gearbox;

   typedef struct packed {
      logic [3:0] t1;
      logic [3:0] t2;
      logic       c1;
      logic       c2;
      logic       k1;
      logic       k2;
   } beat_t;

   logic       clk;
   logic       rst;
   logic [7:0] gmii_txd;
   logic       gmii_tx_en;
   logic       gmii_tx_er;
   logic [1:0] speed;
   logic       mii_tx_ce;
   logic [3:0] txd_d1;
   logic [3:0] txd_d2;
   logic       txctl_d1;
   logic       txctl_d2;
   logic       txclk_d1;
   logic       txclk_d2;

   int checkCount = 0;
   int passCount  = 0;
   beat_t expQ[$];

   rgmii_tx_gearbox dut (
      .clk        (clk),
      .rst        (rst),
      .gmii_txd   (gmii_txd),
      .gmii_tx_en (gmii_tx_en),
      .gmii_tx_er (gmii_tx_er),
      .speed      (speed),
      .mii_tx_ce  (mii_tx_ce),
      .txd_d1     (txd_d1),
      .txd_d2     (txd_d2),
      .txctl_d1   (txctl_d1),
      .txctl_d2   (txctl_d2),
      .txclk_d1   (txclk_d1),
      .txclk_d2   (txclk_d2)
   );

   // 125 MHz clock. Posedges fall at 4 + 8k, negedges at 8k.
   initial clk = 1'b0;
   always #4 clk = ~clk;

   // Queue the full output waveform of one byte, as it should appear
   // starting on the cycle after its boundary.
   task automatic push_byte(input logic [1:0] spd, input logic [7:0] b,
                            input logic en, input logic er);
      beat_t e;
      int    n;
      int    ph;
      logic  ctl2;
`ifdef RGMII_TX_ER_EN
      ctl2 = en ^ er;
`else
      ctl2 = en;
`endif
      if (spd[1]) begin
         e.t1 = b[3:0];
         e.t2 = b[7:4];
         e.c1 = en;
         e.c2 = ctl2;
         e.k1 = 1'b1;
         e.k2 = 1'b0;
         expQ.push_back(e);
      end else begin
         n = spd[0] ? 5 : 50;
         for (int i = 0; i < 2 * n; i++) begin
            ph   = i % n;
            e.t1 = (i < n) ? b[3:0] : b[7:4];
            e.t2 = e.t1;
            e.c1 = en;
            e.c2 = ctl2;
            if (n == 5) begin
               e.k1 = (ph < 3);
               e.k2 = (ph < 2);
            end else begin
               e.k1 = (ph < 25);
               e.k2 = (ph < 25);
            end
            expQ.push_back(e);
         end
      end
   endtask

   // One clock cycle, processed at the negedge:
   //   - sample the DUT and take the model's prediction;
   //   - drive new inputs;
   //   - on a predicted boundary, queue the next byte.
   task automatic run_cycle(input logic [1:0] spd, input logic [7:0] data,
                            input logic en, input logic er,
                            output beat_t obs, output beat_t expv,
                            output logic obsCe, output logic expCe);
      @(negedge clk);
      obs.t1 = txd_d1;
      obs.t2 = txd_d2;
      obs.c1 = txctl_d1;
      obs.c2 = txctl_d2;
      obs.k1 = txclk_d1;
      obs.k2 = txclk_d2;
      obsCe  = mii_tx_ce;
      if (expQ.size() > 0) expv = expQ.pop_front();
      else expv = '0;
      expCe = (expQ.size() == 0);
      speed      = spd;
      gmii_txd   = data;
      gmii_tx_en = en;
      gmii_tx_er = er;
      if (expCe) push_byte(spd, data, en, er);
   endtask

   task automatic test_reset;
      rst        = 1'b1;
      speed      = 2'b10;
      gmii_txd   = 8'h00;
      gmii_tx_en = 1'b0;
      gmii_tx_er = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkCount++;
      if ({txd_d1, txd_d2, txctl_d1, txctl_d2, txclk_d1, txclk_d2} !== 12'h000) begin
         $display("[TB] FAIL reset_outputs: got %h expected 000",
                  {txd_d1, txd_d2, txctl_d1, txctl_d2, txclk_d1, txclk_d2});
      end else passCount++;
      checkCount++;
      if (mii_tx_ce !== 1'b0) $display("[TB] FAIL reset_ce: got %b expected 0", mii_tx_ce);
      else passCount++;
      @(posedge clk);
      #1 rst = 1'b0;
      expQ.delete();
   endtask

   task automatic test_gigabit;
      beat_t obs, expv;
      logic  obsCe, expCe;
      logic [7:0] d;
      for (int i = 0; i < 20; i++) begin
         d = (i == 0) ? 8'h5D : (i == 1) ? 8'hA3 : 8'($urandom());
         run_cycle(2'b10, d, (i < 2) ? 1'b1 : 1'($urandom()), (i < 2) ? 1'b0 : 1'($urandom()),
                   obs, expv, obsCe, expCe);
         checkCount++;
         if (obs !== expv) $display("[TB] FAIL gig_out cyc %0d: got %h expected %h", i, obs, expv);
         else passCount++;
         checkCount++;
         if (obsCe !== expCe) $display("[TB] FAIL gig_ce cyc %0d: got %b expected %b", i, obsCe, expCe);
         else passCount++;
         if (i == 1 || i == 2) begin
            checkCount++;
            if ({obs.t1, obs.t2} !== ((i == 1) ? 8'hD5 : 8'h3A))
               $display("[TB] FAIL gig_txd_pair cyc %0d: got %h expected %h", i, {obs.t1, obs.t2},
                        (i == 1) ? 8'hD5 : 8'h3A);
            else passCount++;
         end
      end
   endtask

   task automatic test_fast;
      beat_t obs, expv;
      logic  obsCe, expCe;
      int    ceSeen = 0;
      for (int i = 0; i < 61; i++) begin
         run_cycle(2'b01, (i == 0) ? 8'h5D : 8'($urandom()), 1'($urandom()), 1'($urandom()),
                   obs, expv, obsCe, expCe);
         if (obsCe === 1'b1) ceSeen++;
         checkCount++;
         if (obs !== expv) $display("[TB] FAIL fast_out cyc %0d: got %h expected %h", i, obs, expv);
         else passCount++;
         checkCount++;
         if (obsCe !== expCe) $display("[TB] FAIL fast_ce cyc %0d: got %b expected %b", i, obsCe, expCe);
         else passCount++;
      end
      // The first cycle is the gigabit boundary. After it, bytes end at cycles 10, 20, ..., 60.
      checkCount++;
      if (ceSeen != 7) $display("[TB] FAIL fast_ce_count: got %0d expected 7", ceSeen);
      else passCount++;
   endtask

   task automatic test_slow;
      beat_t obs, expv;
      logic  obsCe, expCe;
      for (int i = 0; i < 220; i++) begin
         run_cycle(2'b00, 8'($urandom()), 1'($urandom()), 1'($urandom()), obs, expv, obsCe, expCe);
         checkCount++;
         if (obs !== expv) $display("[TB] FAIL slow_out cyc %0d: got %h expected %h", i, obs, expv);
         else passCount++;
         checkCount++;
         if (obsCe !== expCe) $display("[TB] FAIL slow_ce cyc %0d: got %b expected %b", i, obsCe, expCe);
         else passCount++;
      end
   endtask

   task automatic test_tx_er;
      beat_t obs, expv;
      logic  obsCe, expCe;
      logic  ctl2Want;
`ifdef RGMII_TX_ER_EN
      ctl2Want = 1'b0;
`else
      ctl2Want = 1'b1;
`endif
      for (int i = 0; i < 106; i++) begin
         run_cycle(2'b10, 8'($urandom()), 1'b1, 1'b1, obs, expv, obsCe, expCe);
         checkCount++;
         if (obs !== expv) $display("[TB] FAIL txer_out cyc %0d: got %h expected %h", i, obs, expv);
         else passCount++;
         checkCount++;
         if (obsCe !== expCe) $display("[TB] FAIL txer_ce cyc %0d: got %b expected %b", i, obsCe, expCe);
         else passCount++;
         if (i >= 102) begin
            checkCount++;
            if ({obs.c1, obs.c2} !== {1'b1, ctl2Want})
               $display("[TB] FAIL txer_ctl cyc %0d: got %b%b expected 1%b", i, obs.c1, obs.c2, ctl2Want);
            else passCount++;
         end
      end
   endtask

   task automatic test_speed_change;
      beat_t obs, expv;
      logic  obsCe, expCe;
      for (int i = 0; i < 30; i++) begin
         // The switch to 1000M arrives 4 cycles into a 100M byte.
         run_cycle((i < 4) ? 2'b01 : 2'b10, 8'($urandom()), 1'($urandom()), 1'($urandom()),
                   obs, expv, obsCe, expCe);
         checkCount++;
         if (obs !== expv) $display("[TB] FAIL spdchg_out cyc %0d: got %h expected %h", i, obs, expv);
         else passCount++;
         checkCount++;
         if (obsCe !== expCe) $display("[TB] FAIL spdchg_ce cyc %0d: got %b expected %b", i, obsCe, expCe);
         else passCount++;
         if (i >= 11) begin
            checkCount++;
            if (obsCe !== 1'b1) $display("[TB] FAIL spdchg_gig_ce cyc %0d: got %b expected 1", i, obsCe);
            else passCount++;
         end
      end
   endtask

   task automatic test_reset_mid_byte;
      beat_t obs, expv;
      logic  obsCe, expCe;
      for (int i = 0; i < 70; i++) begin
         run_cycle(2'b00, 8'($urandom()) | 8'h11, 1'b1, 1'b0, obs, expv, obsCe, expCe);
         checkCount++;
         if (obs !== expv) $display("[TB] FAIL midrst_pre cyc %0d: got %h expected %h", i, obs, expv);
         else passCount++;
      end
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      checkCount++;
      if ({txd_d1, txd_d2, txctl_d1, txctl_d2, txclk_d1, txclk_d2} !== 12'h000) begin
         $display("[TB] FAIL midrst_outputs: got %h expected 000",
                  {txd_d1, txd_d2, txctl_d1, txctl_d2, txclk_d1, txclk_d2});
      end else passCount++;
      checkCount++;
      if (mii_tx_ce !== 1'b0) $display("[TB] FAIL midrst_ce: got %b expected 0", mii_tx_ce);
      else passCount++;
      expQ.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 120; i++) begin
         run_cycle(2'b00, 8'($urandom()), 1'($urandom()), 1'($urandom()), obs, expv, obsCe, expCe);
         checkCount++;
         if (obs !== expv) $display("[TB] FAIL midrst_post cyc %0d: got %h expected %h", i, obs, expv);
         else passCount++;
         checkCount++;
         if (obsCe !== expCe) $display("[TB] FAIL midrst_ce_post cyc %0d: got %b expected %b", i, obsCe, expCe);
         else passCount++;
         if (i == 0) begin
            checkCount++;
            if (obsCe !== 1'b1) $display("[TB] FAIL midrst_first_ce: got %b expected 1", obsCe);
            else passCount++;
         end
      end
   endtask

   task automatic test_back_to_back;
      beat_t obs, expv;
      logic  obsCe, expCe;
      for (int i = 0; i < 800; i++) begin
         run_cycle(2'($urandom()), 8'($urandom()), 1'($urandom()), 1'($urandom()),
                   obs, expv, obsCe, expCe);
         checkCount++;
         if (obs !== expv) $display("[TB] FAIL b2b_out cyc %0d: got %h expected %h", i, obs, expv);
         else passCount++;
         checkCount++;
         if (obsCe !== expCe) $display("[TB] FAIL b2b_ce cyc %0d: got %b expected %b", i, obsCe, expCe);
         else passCount++;
      end
   endtask

   initial begin
      test_reset();
      test_gigabit();
      test_fast();
      test_slow();
      test_tx_er();
      test_speed_change();
      test_reset_mid_byte();
      test_back_to_back();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/rgmii_tx_gearbox.md
Name: rgmii_tx_gearbox

Overview:
- Stage directly upstream of the generic output-DDR flip-flops on the RGMII transmit path.
- Converts the MAC-side GMII byte stream (8-bit data, tx_en, tx_er) into per-cycle rising/falling-edge pairs (d1/d2) for the data, control and forwarded-clock ODDRs.
- Supports 1000/100/10 Mb/s from a single 125 MHz clock. In 10/100 mode it splits each byte into nibbles, generates the divided forwarded clock, and throttles the MAC with a clock-enable.

Parameters:
- none (all widths are fixed by RGMII)

Ports:
- clk  input  1  125 MHz transmit clock
- rst  input  1  asynchronous reset, active-high
- gmii_txd  input  8  MAC transmit byte
- gmii_tx_en  input  1  MAC transmit enable
- gmii_tx_er  input  1  MAC transmit error
- speed  input  2  00 = 10M, 01 = 100M, 10 = 1000M, 11 = treated as 1000M
- mii_tx_ce  output  1  byte strobe to MAC; MAC must present a new byte in every cycle where this is high
- txd_d1  output  4  rising-edge data nibble, to data ODDR
- txd_d2  output  4  falling-edge data nibble, to data ODDR
- txctl_d1  output  1  rising-edge TX_CTL
- txctl_d2  output  1  falling-edge TX_CTL
- txclk_d1  output  1  rising-half value of the forwarded TXC, to clock ODDR
- txclk_d2  output  1  falling-half value of the forwarded TXC, to clock ODDR

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. All outputs are registered except mii_tx_ce.
- Reset values:
  - All d1/d2 outputs = 0.
  - Period counter cnt = 0, nibble_sel = 0, byte_reg = 0, speed_reg = 10 (1000M).
  - mii_tx_ce = 0 while rst is high.
- speed_reg:
  - Loads speed only at a byte boundary.
  - In 1000M mode, every cycle is a byte boundary.
  - In 10/100 mode, the byte boundary is the cycle where cnt == N-1 and nibble_sel == 1.
- Nibble period N: 5 cycles (100M), 50 cycles (10M).
- 1000M mode:
  - mii_tx_ce = 1 constantly.
  - Each cycle registers txd_d1 = gmii_txd[3:0] and txd_d2 = gmii_txd[7:4].
  - txctl_d1 = tx_en; txctl_d2 = tx_en XOR tx_er.
  - txclk_d1 = 1, txclk_d2 = 0.
  - Latency is 1 cycle from input to d1/d2.
- 10/100 mode:
  - cnt counts 0..N-1 and wraps to 0. nibble_sel toggles on each wrap.
  - mii_tx_ce = 1 only in the byte-boundary cycle. In that cycle, gmii_txd, tx_en and tx_er are captured into byte_reg, en_reg and er_reg.
  - While nibble_sel = 0, txd_d1 = txd_d2 = byte_reg[3:0]. While nibble_sel = 1, both carry byte_reg[7:4]. Each nibble is held for all N cycles of its period.
  - txctl_d1 = en_reg; txctl_d2 = en_reg XOR er_reg. Both are held for the whole byte.
  - Forwarded clock, 100M (N = 5): at cnt 0 and 1, d1 = d2 = 1; at cnt 2, d1 = 1 and d2 = 0; at cnt 3 and 4, d1 = d2 = 0. This gives a 50 % duty cycle at 25 MHz.
  - Forwarded clock, 10M (N = 50): d1 = d2 = 1 for cnt 0..24 and 0 for cnt 25..49, giving 2.5 MHz.
  - Latency: a byte captured at the boundary appears on txd at the next cycle, with cnt = 0 and the low nibble first.
- Speed change:
  - Takes effect only at a byte boundary. cnt and nibble_sel are cleared to 0 when the mode changes.
  - A change from 10/100 to 1000 is applied at the 10/100 byte boundary. mii_tx_ce = 1 from the next cycle.
- Reset mid-byte: in-flight nibbles are discarded and outputs go to 0 immediately (asynchronous). After release, the block resumes in 1000M mode and loads speed at the first boundary.
- tx_en deassertion: this is data like any other. The idle byte is still sequenced, and TXC keeps toggling.

Optional Feature:
- Macro: RGMII_TX_ER_EN.
- Defined: txctl_d2 = tx_en XOR tx_er, as above.
- Not defined: gmii_tx_er is ignored and txctl_d2 = txctl_d1 = tx_en. er_reg is not implemented.

Test Plan:
1. Reset, speed = 10, drive bytes 0x5D, 0xA3 with tx_en = 1. Expect:
   - mii_tx_ce = 1.
   - txd_d1/d2 = 0xD/0x5, then 0x3/0xA, each 1 cycle after its input.
   - txctl = 1/1; txclk = 1/0 throughout.
2. speed = 01, drive 0x5D at the first ce. Expect:
   - txd = 0xD for 5 cycles, then 0x5 for 5 cycles.
   - ce high once per 10 cycles.
   - txclk pattern 11, 11, 10, 00, 00 repeating.
3. speed = 00. Expect:
   - ce period of 100 cycles.
   - txclk high for 25 cycles, then low for 25 cycles.
   - Each nibble held for 50 cycles.
4. With the macro defined, speed = 10, tx_en = 1, tx_er = 1. Expect txctl_d1 = 1, txctl_d2 = 0. Without the macro, expect txctl_d2 = 1.
5. At 100M, switch speed to 10 mid-byte. Expect:
   - The current byte completes at 100M timing.
   - After that boundary, cnt restarts at 0 and 1000M behaviour begins (ce = 1 every cycle).
6. Assert rst during the high nibble at 10M. Expect:
   - All outputs 0 immediately and ce = 0.
   - After release, 1000M behaviour until the first boundary loads speed = 00.
